// File: rtl/merc16_ctrl_pkg.sv
// Shared definitions for the MERC-16 multi-cycle control unit: state and
// opcode-class enums, opcode values, datapath select encodings and the
// bundle of control outputs driven each cycle.
package merc16_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_I_EXEC    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_IMM_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_ADDI, CL_ANDI, CL_ORI, CL_LUI, CL_LLI, CL_LW, CL_SW,
    CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_HALT, CL_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_LUI  = 5'b01011;
  localparam logic [4:0] OP_LLI  = 5'b01100;
  localparam logic [4:0] OP_LW   = 5'b10000;
  localparam logic [4:0] OP_SW   = 5'b10001;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_BNE  = 5'b11001;
  localparam logic [4:0] OP_J    = 5'b11100;
  localparam logic [4:0] OP_JAL  = 5'b11101;
  localparam logic [4:0] OP_JR   = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] PCSRC_INC    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JIMM   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] REGDATA_ALU = 2'b00;
  localparam logic [1:0] REGDATA_MEM = 2'b01;
  localparam logic [1:0] REGDATA_PC  = 2'b10;
  localparam logic [1:0] REGDATA_IMM = 2'b11;

  localparam logic [1:0] REGDEST_RD  = 2'b00;
  localparam logic [1:0] REGDEST_RT  = 2'b01;
  localparam logic [1:0] REGDEST_R15 = 2'b10;

  localparam logic [1:0] ALUB_REG = 2'b00;
  localparam logic [1:0] ALUB_ONE = 2'b01;
  localparam logic [1:0] ALUB_SE  = 2'b10;
  localparam logic [1:0] ALUB_ZE  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  // Every datapath control driven by the FSM in one cycle.
  typedef struct packed {
    logic [1:0] pc_source;
    logic       pc_write;
    logic       inst_data;
    logic       memory_write;
    logic       ir_write;
    logic       write_reg;
    logic [1:0] reg_dest;
    logic [1:0] reg_data;
    logic [1:0] rs_rd;
    logic [1:0] rs_rt;
    logic       upper_lower;
    logic       hold_old_pc;
    logic       old_new;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/merc16_opcode_class.sv
// Combinational decode of the 5-bit MERC-16 opcode into an instruction class.
module merc16_opcode_class
  import merc16_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);

  // Opcode -> class; unlisted encodings become CL_ILLEGAL (executed as NOP).
  always_comb begin
    op_class = CL_ILLEGAL;
    if (opcode[4:3] == 2'b00) begin
      op_class = CL_R;
    end else begin
      case (opcode)
        OP_ADDI: op_class = CL_ADDI;
        OP_ANDI: op_class = CL_ANDI;
        OP_ORI:  op_class = CL_ORI;
        OP_LUI:  op_class = CL_LUI;
        OP_LLI:  op_class = CL_LLI;
        OP_LW:   op_class = CL_LW;
        OP_SW:   op_class = CL_SW;
        OP_BEQ:  op_class = CL_BEQ;
        OP_BNE:  op_class = CL_BNE;
        OP_J:    op_class = CL_J;
        OP_JAL:  op_class = CL_JAL;
        OP_JR:   op_class = CL_JR;
        OP_HALT: op_class = CL_HALT;
        default: op_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/merc16_control_fsm.sv
// MERC-16 multi-cycle Moore control FSM: one state per clock, drives every
// PC/IR/memory/register-file/ALU control. All controls are forced to zero
// while Reset is low so an aborted instruction leaves no partial write.
// Optional feature: define MERC16_RETIRE_COUNT_EN to add RetiredCount.
module merc16_control_fsm
  import merc16_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
`ifdef MERC16_RETIRE_COUNT_EN
  ,
  parameter int RETIRE_W = 16
`endif
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [4:0]         Opcode,
  input  logic               Zero,
  output logic [1:0]         PC_Source,
  output logic               PC_Write,
  output logic               InstData,
  output logic               MemoryWrite,
  output logic               IR_Write,
  output logic               WriteReg,
  output logic [1:0]         RegDest,
  output logic [1:0]         RegData,
  output logic [1:0]         RsRd,
  output logic [1:0]         RsRt,
  output logic               UpperLower,
  output logic               HoldOldPCValue,
  output logic               OldNew,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Halted,
`ifdef MERC16_RETIRE_COUNT_EN
  output logic [RETIRE_W-1:0] RetiredCount,
`endif
  output logic [3:0]         State
);

  state_t    state_reg, state_next;
  op_class_t op_class, class_reg;
  logic [2:0] func_reg;
  ctrl_t     ctrl_next, ctrl;

  merc16_opcode_class u_opcode_class (
    .opcode   (Opcode),
    .op_class (op_class)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // Latch the instruction class and R-type function while in DECODE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      class_reg <= CL_ILLEGAL;
      func_reg  <= 3'd0;
    end else if (state_reg == S_DECODE) begin
      class_reg <= op_class;
      func_reg  <= Opcode[2:0];
    end
  end

  // Next-state logic; DECODE dispatches on the live class.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CL_R:                     state_next = S_R_EXEC;
          CL_ADDI, CL_ANDI, CL_ORI: state_next = S_I_EXEC;
          CL_LUI, CL_LLI:           state_next = S_IMM_WB;
          CL_LW, CL_SW:             state_next = S_MEM_ADDR;
          CL_BEQ, CL_BNE:           state_next = S_BRANCH;
          CL_J, CL_JAL, CL_JR:      state_next = S_JUMP;
          CL_HALT:                  state_next = S_HALT;
          default:                  state_next = S_FETCH;
        endcase
      end
      S_R_EXEC, S_I_EXEC: state_next = S_ALU_WB;
      S_MEM_ADDR: state_next = (class_reg == CL_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_next = S_MEM_WB;
      S_ALU_WB, S_IMM_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP:
                  state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore output decode; only BRANCH looks at an input (Zero).
  always_comb begin
    ctrl_next = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl_next.ir_write    = 1'b1;
        ctrl_next.hold_old_pc = 1'b1;
        ctrl_next.alu_src_b   = ALUB_ONE;
        ctrl_next.alu_op      = ALU_ADD;
        ctrl_next.pc_source   = PCSRC_INC;
        ctrl_next.pc_write    = 1'b1;
      end
      S_DECODE: begin
        ctrl_next.alu_src_b = ALUB_SE;
        ctrl_next.alu_op    = ALU_ADD;
      end
      S_R_EXEC: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = ALUB_REG;
        ctrl_next.alu_op    = {1'b0, func_reg};
      end
      S_I_EXEC: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = (class_reg == CL_ADDI) ? ALUB_SE : ALUB_ZE;
        ctrl_next.alu_op    = (class_reg == CL_ADDI) ? ALU_ADD :
                              (class_reg == CL_ANDI) ? ALU_AND : ALU_OR;
      end
      S_ALU_WB: begin
        ctrl_next.write_reg = 1'b1;
        ctrl_next.reg_data  = REGDATA_ALU;
        ctrl_next.reg_dest  = (class_reg == CL_R) ? REGDEST_RD : REGDEST_RT;
      end
      S_IMM_WB: begin
        ctrl_next.write_reg   = 1'b1;
        ctrl_next.reg_data    = REGDATA_IMM;
        ctrl_next.reg_dest    = REGDEST_RT;
        ctrl_next.upper_lower = (class_reg == CL_LUI);
      end
      S_MEM_ADDR: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = ALUB_SE;
        ctrl_next.alu_op    = ALU_ADD;
      end
      S_MEM_READ: ctrl_next.inst_data = 1'b1;
      S_MEM_WB: begin
        ctrl_next.write_reg = 1'b1;
        ctrl_next.reg_data  = REGDATA_MEM;
        ctrl_next.reg_dest  = REGDEST_RT;
      end
      S_MEM_WRITE: begin
        ctrl_next.inst_data    = 1'b1;
        ctrl_next.memory_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = ALUB_REG;
        ctrl_next.alu_op    = ALU_SUB;
        ctrl_next.pc_source = PCSRC_BRANCH;
        ctrl_next.pc_write  = (class_reg == CL_BEQ) ? Zero : ~Zero;
      end
      S_JUMP: begin
        ctrl_next.pc_write  = 1'b1;
        ctrl_next.pc_source = (class_reg == CL_JR) ? PCSRC_REGA : PCSRC_JIMM;
        if (class_reg == CL_JAL) begin
          ctrl_next.write_reg = 1'b1;
          ctrl_next.reg_dest  = REGDEST_R15;
          ctrl_next.reg_data  = REGDATA_PC;
          ctrl_next.old_new   = 1'b0;
        end
      end
      S_HALT:  ctrl_next.halted = 1'b1;
      default: ctrl_next = '0;
    endcase
  end

  assign ctrl = Reset ? ctrl_next : '0;

  assign PC_Source      = ctrl.pc_source;
  assign PC_Write       = ctrl.pc_write;
  assign InstData       = ctrl.inst_data;
  assign MemoryWrite    = ctrl.memory_write;
  assign IR_Write       = ctrl.ir_write;
  assign WriteReg       = ctrl.write_reg;
  assign RegDest        = ctrl.reg_dest;
  assign RegData        = ctrl.reg_data;
  assign RsRd           = ctrl.rs_rd;
  assign RsRt           = ctrl.rs_rt;
  assign UpperLower     = ctrl.upper_lower;
  assign HoldOldPCValue = ctrl.hold_old_pc;
  assign OldNew         = ctrl.old_new;
  assign ALUSrcA        = ctrl.alu_src_a;
  assign ALUSrcB        = ctrl.alu_src_b;
  assign ALUOp          = ALUOP_W'(ctrl.alu_op);
  assign Halted         = ctrl.halted;
  assign State          = state_reg;

`ifdef MERC16_RETIRE_COUNT_EN
  logic [RETIRE_W-1:0] retired_reg;

  // Count every return to FETCH; wraps naturally at all-ones.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) retired_reg <= '0;
    else if (state_reg != S_FETCH && state_next == S_FETCH)
      retired_reg <= retired_reg + 1'b1;
  end

  assign RetiredCount = retired_reg;
`endif

endmodule

// File: tb/tb_merc16_control_fsm.sv
// Self-checking bench for merc16_control_fsm. The reference model describes
// each instruction as a list of per-cycle control vectors derived from the
// instruction's micro-sequence (cycle 0 fetch, cycle 1 decode, then
// instruction-specific cycles), independent of the DUT's state encoding.
module tb_merc16_control_fsm;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [4:0] Opcode = 5'd0;
  logic       Zero = 1'b0;
  logic [1:0] PC_Source, RegDest, RegData, RsRd, RsRt, ALUSrcB;
  logic       PC_Write, InstData, MemoryWrite, IR_Write, WriteReg;
  logic       UpperLower, HoldOldPCValue, OldNew, ALUSrcA, Halted;
  logic [3:0] ALUOp;
  logic [3:0] State;
`ifdef MERC16_RETIRE_COUNT_EN
  logic [15:0] RetiredCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int exp_retired = 0;

  localparam logic [4:0] T_ADD  = 5'b00000, T_ADDI = 5'b01000, T_ANDI = 5'b01001;
  localparam logic [4:0] T_ORI  = 5'b01010, T_LUI  = 5'b01011, T_LLI  = 5'b01100;
  localparam logic [4:0] T_LW   = 5'b10000, T_SW   = 5'b10001, T_BEQ  = 5'b11000;
  localparam logic [4:0] T_BNE  = 5'b11001, T_J    = 5'b11100, T_JAL  = 5'b11101;
  localparam logic [4:0] T_JR   = 5'b11110, T_HALT = 5'b11111;

  merc16_control_fsm dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .PC_Source(PC_Source), .PC_Write(PC_Write), .InstData(InstData),
    .MemoryWrite(MemoryWrite), .IR_Write(IR_Write), .WriteReg(WriteReg),
    .RegDest(RegDest), .RegData(RegData), .RsRd(RsRd), .RsRt(RsRt),
    .UpperLower(UpperLower), .HoldOldPCValue(HoldOldPCValue), .OldNew(OldNew),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Halted(Halted),
`ifdef MERC16_RETIRE_COUNT_EN
    .RetiredCount(RetiredCount),
`endif
    .State(State)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic logic [25:0] got_vec();
    return {PC_Source, PC_Write, InstData, MemoryWrite, IR_Write, WriteReg,
            RegDest, RegData, RsRd, RsRt, UpperLower, HoldOldPCValue, OldNew,
            ALUSrcA, ALUSrcB, ALUOp, Halted};
  endfunction

  function automatic bit is_illegal(input logic [4:0] op);
    return !(op[4:3] == 2'b00 || op == T_ADDI || op == T_ANDI || op == T_ORI ||
             op == T_LUI || op == T_LLI || op == T_LW || op == T_SW ||
             op == T_BEQ || op == T_BNE || op == T_J || op == T_JAL ||
             op == T_JR || op == T_HALT);
  endfunction

  // Number of clock cycles each instruction occupies (HALT: up to entering HALT).
  function automatic int ncyc(input logic [4:0] op);
    if (is_illegal(op)) return 2;
    if (op[4:3] == 2'b00 || op == T_ADDI || op == T_ANDI || op == T_ORI) return 4;
    if (op == T_LW) return 5;
    if (op == T_SW) return 4;
    return 3;
  endfunction

  // Expected control vector for cycle c of instruction op.
  function automatic logic [25:0] model(input logic [4:0] op, input int c, input logic z);
    logic [1:0] pcs = 0, rdst = 0, rdat = 0, asb = 0;
    logic pcw = 0, idata = 0, mw = 0, irw = 0, wr = 0, ulow = 0, hold = 0;
    logic oldnew = 0, asa = 0, hlt = 0;
    logic [3:0] aop = 0;
    if (c == 0) begin
      irw = 1; hold = 1; asb = 2'b01; pcw = 1;
    end else if (c == 1) begin
      asb = 2'b10;
    end else if (op[4:3] == 2'b00) begin
      if (c == 2) begin asa = 1; aop = {1'b0, op[2:0]}; end
      else wr = 1;
    end else if (op == T_ADDI || op == T_ANDI || op == T_ORI) begin
      if (c == 2) begin
        asa = 1;
        asb = (op == T_ADDI) ? 2'b10 : 2'b11;
        aop = (op == T_ADDI) ? 4'd0 : (op == T_ANDI) ? 4'd2 : 4'd3;
      end else begin
        wr = 1; rdst = 2'b01;
      end
    end else if (op == T_LUI || op == T_LLI) begin
      wr = 1; rdat = 2'b11; rdst = 2'b01; ulow = (op == T_LUI);
    end else if (op == T_LW || op == T_SW) begin
      if (c == 2) begin asa = 1; asb = 2'b10; end
      else if (op == T_SW) begin idata = 1; mw = 1; end
      else if (c == 3) idata = 1;
      else begin wr = 1; rdat = 2'b01; rdst = 2'b01; end
    end else if (op == T_BEQ || op == T_BNE) begin
      asa = 1; aop = 4'd1; pcs = 2'b01;
      pcw = (op == T_BEQ) ? z : ~z;
    end else if (op == T_J || op == T_JAL || op == T_JR) begin
      pcw = 1;
      pcs = (op == T_JR) ? 2'b11 : 2'b10;
      if (op == T_JAL) begin wr = 1; rdst = 2'b10; rdat = 2'b10; end
    end else if (op == T_HALT) begin
      hlt = 1;
    end
    return {pcs, pcw, idata, mw, irw, wr, rdst, rdat, 2'b00, 2'b00, ulow, hold,
            oldnew, asa, asb, aop, hlt};
  endfunction

  // Runs one instruction starting just after the edge that enters its fetch
  // cycle. abort_at >= 0 stops at that cycle's sample point without advancing.
  task automatic run_instr(input logic [4:0] op, input logic z, input int abort_at);
    int n = ncyc(op);
    logic [25:0] got, exp;
    bit ok = 1;
    for (int c = 0; c < n; c++) begin
      Opcode = (c == 0) ? 5'($urandom_range(0, 31)) : op;
      Zero   = (c == 2) ? z : 1'($urandom_range(0, 1));
      @(negedge Clock);
      got = got_vec();
      exp = model(op, c, Zero);
      n_checks++;
      if (got !== exp) begin
        $display("FAIL ctrl op=%b cycle=%0d got=%b want=%b", op, c, got, exp);
        ok = 0;
      end else n_pass++;
`ifdef MERC16_RETIRE_COUNT_EN
      if (c == 0) begin
        n_checks++;
        if (RetiredCount !== 16'(exp_retired))
          $display("FAIL retired op=%b got=%0d want=%0d", op, RetiredCount, exp_retired);
        else n_pass++;
      end
`endif
      if (c == abort_at) begin
        $display("instr op=%b zero=%b aborted at cycle %0d state=%0d", op, z, c, State);
        return;
      end
      @(posedge Clock); #1;
    end
    if (op != T_HALT) exp_retired = (exp_retired + 1) % 65536;
    $display("instr op=%b zero=%b cycles=%0d %s", op, z, n, ok ? "ok" : "bad");
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (got_vec() !== 26'd0) $display("FAIL %s got=%b want=0", name, got_vec());
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      check_zero("reset_outputs");
    end
    @(posedge Clock); #1;
    Reset = 1'b1;
    exp_retired = 0;
    $display("reset released");
  endtask

  task automatic test_add();
    run_instr(T_ADD, 1'b0, -1);
  endtask

  task automatic test_lw_sw_imm();
    run_instr(T_LW, 1'b0, -1);
    run_instr(T_SW, 1'b1, -1);
    run_instr(T_ADDI, 1'b0, -1);
    run_instr(T_ANDI, 1'b0, -1);
    run_instr(T_ORI, 1'b0, -1);
    run_instr(T_LUI, 1'b0, -1);
    run_instr(T_LLI, 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr(T_BEQ, 1'b1, -1);
    run_instr(T_BEQ, 1'b0, -1);
    run_instr(T_BNE, 1'b1, -1);
    run_instr(T_BNE, 1'b0, -1);
  endtask

  task automatic test_jump_illegal();
    run_instr(T_J, 1'b0, -1);
    run_instr(T_JAL, 1'b0, -1);
    run_instr(T_JR, 1'b0, -1);
    run_instr(5'b01101, 1'b0, -1);
    run_instr(5'b10111, 1'b1, -1);
  endtask

  task automatic test_halt();
    run_instr(T_HALT, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      Opcode = 5'($urandom_range(0, 31));
      Zero   = 1'($urandom_range(0, 1));
      @(negedge Clock);
      n_checks++;
      if (got_vec() !== 26'd1) $display("FAIL halt_hold cycle=%0d got=%b want=%b", i, got_vec(), 26'd1);
      else n_pass++;
      @(posedge Clock); #1;
    end
    Reset = 1'b0; #2;
    check_zero("halt_reset_low");
    @(posedge Clock); #1;
    Reset = 1'b1;
    exp_retired = 0;
    #1;
    n_checks++;
    if (Halted !== 1'b0 || IR_Write !== 1'b1)
      $display("FAIL halt_exit got Halted=%b IR_Write=%b want Halted=0 IR_Write=1", Halted, IR_Write);
    else n_pass++;
    $display("halt held 20 cycles, reset pulse returned to fetch");
  endtask

  task automatic test_reset_mid_sw();
    run_instr(T_SW, 1'b0, 3);
    #1 Reset = 1'b0;
    #1;
    n_checks++;
    if (MemoryWrite !== 1'b0) $display("FAIL abort_memwrite got=%b want=0", MemoryWrite);
    else n_pass++;
    check_zero("abort_outputs");
    @(posedge Clock); #1;
    Reset = 1'b1;
    exp_retired = 0;
    run_instr(T_ADD, 1'b0, -1);
    run_instr(T_LW, 1'b0, -1);
    run_instr(T_BNE, 1'b0, -1);
    run_instr(T_J, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == T_HALT) op = T_JAL;
      run_instr(op, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_sw_imm();
    test_branch();
    test_jump_illegal();
    test_halt();
    test_reset_mid_sw();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
